// File: rtl/column_drop_writer_pkg.sv
// Shared constants and types for the Connect Four column writer.
// Board geometry, player encodings and FSM states.
package column_drop_writer_pkg;

    localparam int COLS   = 7;
    localparam int ROWS   = 6;
    localparam int COL_W  = 3;
    localparam int MOVE_W = 6;
    localparam int ROW_W  = 3;

    localparam logic PLAYER0 = 1'b0;
    localparam logic PLAYER1 = 1'b1;

    // Total cells on the board; reaching this count without a win is a draw.
    localparam logic [MOVE_W-1:0] CELLS = MOVE_W'(COLS * ROWS);

    // Column count widened by one bit so it can be compared with drop_col.
    localparam logic [COL_W:0] COLS_LIM = (COL_W + 1)'(COLS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CHECK = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    // One-hot mask selecting a single row within a column.
    function automatic logic [ROWS-1:0] row_mask(input logic [ROW_W-1:0] r);
        return ROWS'(1) << r;
    endfunction

endpackage

// File: rtl/column_drop_writer_lowest_empty_row.sv
// Priority encoder: finds the lowest unoccupied row of a column.
// Also flags a column with no empty row.
module lowest_empty_row #(
    parameter int ROWS  = 6,
    parameter int ROW_W = 3
) (
    input  logic [ROWS-1:0]  col_i,
    output logic [ROW_W-1:0] row_o,
    output logic             full_o
);

    // Scan from the top down so the lowest zero bit wins.
    always_comb begin
        row_o  = '0;
        full_o = &col_i;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!col_i[i]) begin
                row_o = ROW_W'(i);
            end
        end
    end

endmodule

// File: rtl/column_drop_writer.sv
// Connect Four board owner: lands dropped pieces, hands the column to
// the win checker, then toggles the turn or ends the game.
module column_drop_writer
    import column_drop_writer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              new_game,
    input  logic              drop_valid,
    input  logic [COL_W-1:0]  drop_col,
    output logic              drop_ready,
    output logic              drop_error,
    output logic              check_valid,
    output logic [ROWS-1:0]   chk_player_register,
    output logic [ROWS-1:0]   chk_onoff_register,
    output logic              chk_player,
    output logic [ROW_W-1:0]  landed_row,
    input  logic              wongame,
    output logic              game_over,
    output logic              winner,
    output logic              draw,
    output logic              cur_player,
    output logic [MOVE_W-1:0] move_count,
    input  logic [COL_W-1:0]  rd_col,
    output logic [ROWS-1:0]   rd_player_register,
    output logic [ROWS-1:0]   rd_onoff_register
);

    state_e state_q, state_d;

    logic [ROWS-1:0]   onoff_q  [COLS];
    logic [ROWS-1:0]   onoff_d  [COLS];
    logic [ROWS-1:0]   player_q [COLS];
    logic [ROWS-1:0]   player_d [COLS];

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              cur_q, cur_d;
    logic [MOVE_W-1:0] moves_q, moves_d;
    logic              over_q, over_d;
    logic              win_q, win_d;
    logic              draw_q, draw_d;
    logic              err_q, err_d;
    logic [ROWS-1:0]   chk_on_q, chk_on_d;
    logic [ROWS-1:0]   chk_pl_q, chk_pl_d;
    logic              chk_who_q, chk_who_d;

    logic [ROWS-1:0]   sel_onoff;
    logic [ROW_W-1:0]  free_row;
    logic              col_full;
    logic              col_ok;
    logic [ROWS-1:0]   mask;

    assign col_ok = {1'b0, drop_col} < COLS_LIM;
    assign mask   = row_mask(row_q);

    // Occupancy of the requested column; empty for out-of-range columns.
    always_comb begin
        sel_onoff = '0;
        for (int c = 0; c < COLS; c++) begin
            if (drop_col == COL_W'(c)) begin
                sel_onoff = onoff_q[c];
            end
        end
    end

    lowest_empty_row #(
        .ROWS  (ROWS),
        .ROW_W (ROW_W)
    ) u_ler (
        .col_i  (sel_onoff),
        .row_o  (free_row),
        .full_o (col_full)
    );

    // Display read port; out-of-range columns read as empty.
    always_comb begin
        rd_onoff_register  = '0;
        rd_player_register = '0;
        for (int c = 0; c < COLS; c++) begin
            if (rd_col == COL_W'(c)) begin
                rd_onoff_register  = onoff_q[c];
                rd_player_register = player_q[c];
            end
        end
    end

    // Next-state and datapath updates; new_game overrides everything.
    always_comb begin
        state_d   = state_q;
        onoff_d   = onoff_q;
        player_d  = player_q;
        col_d     = col_q;
        row_d     = row_q;
        cur_d     = cur_q;
        moves_d   = moves_q;
        over_d    = over_q;
        win_d     = win_q;
        draw_d    = draw_q;
        err_d     = 1'b0;
        chk_on_d  = chk_on_q;
        chk_pl_d  = chk_pl_q;
        chk_who_d = chk_who_q;

        unique case (state_q)
            ST_IDLE: begin
                if (drop_valid && drop_ready) begin
                    if (!col_ok || col_full) begin
                        err_d = 1'b1;
                    end else begin
                        col_d   = drop_col;
                        row_d   = free_row;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                for (int c = 0; c < COLS; c++) begin
                    if (col_q == COL_W'(c)) begin
                        onoff_d[c]  = onoff_q[c] | mask;
                        player_d[c] = (player_q[c] & ~mask)
                                    | ((cur_q == PLAYER1) ? mask : '0);
                        chk_on_d    = onoff_d[c];
                        chk_pl_d    = player_d[c];
                    end
                end
                chk_who_d = cur_q;
                moves_d   = moves_q + MOVE_W'(1);
                state_d   = ST_CHECK;
            end
            ST_CHECK: begin
                if (wongame) begin
                    over_d  = 1'b1;
                    win_d   = cur_q;
                    state_d = ST_OVER;
                end else if (moves_q == CELLS) begin
                    over_d  = 1'b1;
                    draw_d  = 1'b1;
                    state_d = ST_OVER;
                end else begin
                    cur_d   = ~cur_q;
                    state_d = ST_IDLE;
                end
            end
            ST_OVER: begin
                state_d = ST_OVER;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (new_game) begin
            state_d   = ST_IDLE;
            col_d     = '0;
            row_d     = '0;
            cur_d     = PLAYER0;
            moves_d   = '0;
            over_d    = 1'b0;
            win_d     = 1'b0;
            draw_d    = 1'b0;
            err_d     = 1'b0;
            chk_on_d  = '0;
            chk_pl_d  = '0;
            chk_who_d = 1'b0;
            for (int c = 0; c < COLS; c++) begin
                onoff_d[c]  = '0;
                player_d[c] = '0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Board storage, game status and checker-facing registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q     <= '0;
            row_q     <= '0;
            cur_q     <= PLAYER0;
            moves_q   <= '0;
            over_q    <= 1'b0;
            win_q     <= 1'b0;
            draw_q    <= 1'b0;
            err_q     <= 1'b0;
            chk_on_q  <= '0;
            chk_pl_q  <= '0;
            chk_who_q <= 1'b0;
            for (int c = 0; c < COLS; c++) begin
                onoff_q[c]  <= '0;
                player_q[c] <= '0;
            end
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            cur_q     <= cur_d;
            moves_q   <= moves_d;
            over_q    <= over_d;
            win_q     <= win_d;
            draw_q    <= draw_d;
            err_q     <= err_d;
            chk_on_q  <= chk_on_d;
            chk_pl_q  <= chk_pl_d;
            chk_who_q <= chk_who_d;
            for (int c = 0; c < COLS; c++) begin
                onoff_q[c]  <= onoff_d[c];
                player_q[c] <= player_d[c];
            end
        end
    end

    assign drop_ready          = (state_q == ST_IDLE) && !over_q;
    assign check_valid         = (state_q == ST_CHECK);
    assign drop_error          = err_q;
    assign chk_onoff_register  = chk_on_q;
    assign chk_player_register = chk_pl_q;
    assign chk_player          = chk_who_q;
    assign landed_row          = row_q;
    assign game_over           = over_q;
    assign winner              = win_q;
    assign draw                = draw_q;
    assign cur_player          = cur_q;
    assign move_count          = moves_q;

endmodule
